// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scan controller: function codes,
// FSM encoding and the hex segment pattern table.
package seven_segment_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [2:0] FUNC_RAW0 = 3'd0;
  localparam logic [2:0] FUNC_RAW1 = 3'd1;
  localparam logic [2:0] FUNC_RAW2 = 3'd2;
  localparam logic [2:0] FUNC_RAW3 = 3'd3;
  localparam logic [2:0] FUNC_HEX  = 3'd4;
  localparam logic [2:0] FUNC_DEC  = 3'd5;
  localparam logic [2:0] FUNC_DP   = 3'd6;
  localparam logic [2:0] FUNC_NOP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Segment order is g..a, bit 0 = segment a, active-high.
  function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_segment_digit_decode.sv
// Combinational next-value computation for one digit register; shared by all
// digits, the digit index arrives as a port.
module seven_segment_digit_decode
  import seven_segment_pkg::*;
(
  input  logic [7:0]  i_current,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_function,
  input  logic [1:0]  i_index,
  output logic [7:0]  o_next
);

  logic [3:0] w_nibble;
  logic       w_dp_bit;
  logic       w_unused_data;

  assign w_nibble      = i_data[{1'b0, i_index, 2'b00} +: 4];
  assign w_dp_bit      = i_data[{3'b000, i_index}];
  assign w_unused_data = ^i_data[31:16];

  // NOTE: o_next gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    o_next = i_current;
    case (i_function)
      FUNC_HEX: o_next = {i_current[7], hex_pattern(w_nibble)};
      FUNC_DEC: o_next = {i_current[7], (w_nibble > 4'd9) ? 7'd0 : hex_pattern(w_nibble)};
      FUNC_DP:  o_next = {w_dp_bit, i_current[6:0]};
      FUNC_NOP: o_next = i_current;
      default: begin
        // Raw writes: only the addressed digit takes the low data byte.
        if (i_function[1:0] == i_index) o_next = i_data[7:0];
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Four-digit seven-segment controller: command FSM applying updates one digit
// per cycle, plus a free-running scan that drives active-low display lines.
module seven_segment_scan_controller
  import seven_segment_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [2:0]  cmdFunction,
  input  logic [31:0] cmdData,
  output logic        cmdDone,
  input  logic        displayEnable,
  output logic [3:0]  digitSelectN,
  output logic [7:0]  segmentsN,
  output logic [31:0] digitValues
);

  localparam int               PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_alive;
  logic [2:0]        r_function;
  logic [31:0]       r_data;
  logic [1:0]        r_index;
  logic [7:0]        r_digit [NUM_DIGITS];
  logic [PRE_W-1:0]  r_prescaler;
  logic [1:0]        r_scan_index;
  logic [3:0]        r_digit_sel_n;
  logic [7:0]        r_segments_n;
  logic              w_accept;
  logic              w_write;
  logic [7:0]        w_digit_next;

  // r_alive holds cmdReady low until the first cycle after reset is released.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmdReady     = 1'b0;
    cmdDone      = 1'b0;
    w_accept     = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmdReady = r_alive;
        if (cmdValid && r_alive) begin
          w_accept     = 1'b1;
          w_state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_write = 1'b1;
        if (r_index == 2'd3) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        cmdDone      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_function <= FUNC_NOP;
      r_data     <= 32'd0;
      r_index    <= 2'd0;
    end else if (w_accept) begin
      r_function <= cmdFunction;
      r_data     <= cmdData;
      r_index    <= 2'd0;
    end else if (w_write) begin
      r_index <= r_index + 2'd1;
    end
  end

  seven_segment_digit_decode u_decode (
    .i_current  (r_digit[r_index]),
    .i_data     (r_data),
    .i_function (r_function),
    .i_index    (r_index),
    .o_next     (w_digit_next)
  );

  // NOTE: the digit array is reset explicitly; it is visible display state,
  // not scratch storage, so it must come up as zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 8'd0;
    end else if (w_write) begin
      r_digit[r_index] <= w_digit_next;
    end
  end

  // Scan timing runs regardless of the FSM and of displayEnable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prescaler  <= '0;
      r_scan_index <= 2'd0;
    end else if (r_prescaler == PRE_MAX) begin
      r_prescaler  <= '0;
      r_scan_index <= r_scan_index + 2'd1;
    end else begin
      r_prescaler <= r_prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_digit_sel_n <= 4'hF;
      r_segments_n  <= 8'hFF;
    end else if (displayEnable) begin
      r_digit_sel_n <= ~(4'b0001 << r_scan_index);
      r_segments_n  <= ~r_digit[r_scan_index];
    end else begin
      r_digit_sel_n <= 4'hF;
      r_segments_n  <= 8'hFF;
    end
  end

  assign digitSelectN = r_digit_sel_n;
  assign segmentsN    = r_segments_n;
  assign digitValues  = {r_digit[3], r_digit[2], r_digit[1], r_digit[0]};

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller (SCAN_DIV = 2).
`timescale 1ns/1ps
module tb_seven_segment_scan_controller;

  logic        clock;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [2:0]  cmdFunction;
  logic [31:0] cmdData;
  logic        cmdDone;
  logic        displayEnable;
  logic [3:0]  digitSelectN;
  logic [7:0]  segmentsN;
  logic [31:0] digitValues;

  int n_vec  = 0;
  int n_miss = 0;

  seven_segment_scan_controller #(.SCAN_DIV(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .cmdValid      (cmdValid),
    .cmdReady      (cmdReady),
    .cmdFunction   (cmdFunction),
    .cmdData       (cmdData),
    .cmdDone       (cmdDone),
    .displayEnable (displayEnable),
    .digitSelectN  (digitSelectN),
    .segmentsN     (segmentsN),
    .digitValues   (digitValues)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one command, tracks ready/done for 8 cycles after the accept edge.
  // With hold set, valid stays high with different payload while busy.
  task automatic do_cmd(input string tag, input logic [2:0] f, input logic [31:0] d,
                        input bit hold, input logic [31:0] exp_values);
    int lat;
    int low;
    int dones;
    lat   = -1;
    low   = 0;
    dones = 0;
    check({tag, "_ready_pre"}, 32'(cmdReady), 32'd1);
    cmdFunction = f;
    cmdData     = d;
    cmdValid    = 1'b1;
    tick();
    if (hold) begin
      cmdFunction = 3'd4;
      cmdData     = 32'hFFFF_FFFF;
    end else begin
      cmdValid = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      if (j == 4) cmdValid = 1'b0;
      if (!cmdReady) low++;
      if (cmdDone) begin
        dones++;
        if (lat < 0) lat = j;
      end
      tick();
    end
    check({tag, "_done_latency"}, 32'(lat), 32'd4);
    check({tag, "_ready_low"}, 32'(low), 32'd5);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_values"}, digitValues, exp_values);
  endtask

  initial begin
    logic [3:0] prev_sel;
    bit         found;
    int         dones;
    logic [3:0] sel_exp [8];
    logic [7:0] seg_exp [4];

    reset         = 1'b0;
    cmdValid      = 1'b0;
    cmdFunction   = 3'd0;
    cmdData       = 32'd0;
    displayEnable = 1'b0;
    repeat (3) tick();

    check("rst_ready", 32'(cmdReady), 32'd0);
    check("rst_done", 32'(cmdDone), 32'd0);
    check("rst_sel", 32'(digitSelectN), 32'hF);
    check("rst_seg", 32'(segmentsN), 32'hFF);
    check("rst_values", digitValues, 32'd0);

    reset = 1'b1;
    tick();
    check("ready_after_release", 32'(cmdReady), 32'd1);

    do_cmd("hex1234", 3'd4, 32'h0000_1234, 1'b0, 32'h065B_4F66);
    do_cmd("dp5", 3'd6, 32'h0000_0005, 1'b0, 32'h06DB_4FE6);
    do_cmd("dec9A", 3'd5, 32'h0000_009A, 1'b0, 32'h3FBF_6F80);
    do_cmd("raw2_hold", 3'd2, 32'h0000_00AB, 1'b1, 32'h3FAB_6F80);
    do_cmd("raw3", 3'd3, 32'h5555_5512, 1'b0, 32'h12AB_6F80);
    do_cmd("nop", 3'd7, 32'hDEAD_BEEF, 1'b0, 32'h12AB_6F80);

    // Scan with SCAN_DIV = 2: each digit is shown for two cycles.
    sel_exp = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
    seg_exp = '{8'h7F, 8'h90, 8'h54, 8'hED};
    displayEnable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      prev_sel = digitSelectN;
      tick();
      if (prev_sel == 4'h7 && digitSelectN == 4'hE) found = 1'b1;
    end
    check("scan_sync", 32'(found), 32'd1);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("scan_sel_%0d", k), 32'(digitSelectN), 32'(sel_exp[k % 8]));
      check($sformatf("scan_seg_%0d", k), 32'(segmentsN), 32'(seg_exp[(k / 2) % 4]));
      tick();
    end

    displayEnable = 1'b0;
    tick();
    check("blank_sel", 32'(digitSelectN), 32'hF);
    check("blank_seg", 32'(segmentsN), 32'hFF);

    // Reset while digit 2 of a hex command is being processed.
    displayEnable = 1'b1;
    cmdFunction   = 3'd4;
    cmdData       = 32'h0000_5678;
    cmdValid      = 1'b1;
    tick();
    cmdValid = 1'b0;
    tick();
    tick();
    check("abort_partial", digitValues, 32'h12AB_07FF);
    reset = 1'b0;
    tick();
    check("abort_values", digitValues, 32'd0);
    check("abort_done", 32'(cmdDone), 32'd0);
    check("abort_ready", 32'(cmdReady), 32'd0);
    check("abort_sel", 32'(digitSelectN), 32'hF);
    check("abort_seg", 32'(segmentsN), 32'hFF);
    reset = 1'b1;
    tick();
    check("abort_ready_release", 32'(cmdReady), 32'd1);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (cmdDone) dones++;
      tick();
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_values_hold", digitValues, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
